// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: validates job geometry, issues one image/kernel read
// per (kernel, output, tap) and drives latency-aligned accumulate/write strobes.
module conv_seq_ctrl #(
  parameter int RD_LAT = 1,
  parameter int IA_W   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            soft_reset,
  input  logic [2:0]      kern_cols,
  input  logic [7:0]      cols,
  input  logic [2:0]      kerns,
  input  logic [7:0]      stride,
  input  logic [7:0]      result_cols,
  input  logic            dp_ready,
  input  logic            accum_ovrflow,
  output logic            rd_en,
  output logic [IA_W-1:0] img_addr,
  output logic [5:0]      kern_addr,
  output logic            acc_clr,
  output logic            acc_en,
  output logic            res_wr,
  output logic [10:0]     res_addr,
  output logic            busy,
  output logic            done,
  output logic            err_bounds,
  output logic            ovf_flag,
  output logic [2:0]      state_dbg
);

  // Handshake: an issue happens on every clock edge where rd_en=1, and rd_en
  // is only raised in RUN while dp_ready=1; dp_ready=0 freezes the counters.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DW = $clog2(RD_LAT + 2);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(RD_LAT);

  state_t state, state_nxt;

  logic            start_d, launch;
  logic [2:0]      kc_s, kerns_s;
  logic [7:0]      cols_s, rc_s, stride_s;
  logic [2:0]      t_cnt, k_cnt;
  logic [7:0]      r_cnt;
  logic [IA_W-1:0] r_base;
  logic [5:0]      k_base;
  logic [10:0]     out_idx;
  logic [DW-1:0]   drain_cnt;
  logic [16:0]     span;
  logic            geom_zero, geom_oob;
  logic            t_last, r_last, k_last;

  logic [RD_LAT-1:0] en_dl, first_dl, last_dl;
  logic [10:0]       addr_dl [RD_LAT];

  assign launch    = start & ~start_d;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Full-width span so large stride*result_cols products cannot wrap.
  assign span      = (({9'd0, rc_s} - 17'd1) * {9'd0, stride_s}) + {14'd0, kc_s};
  assign geom_zero = (kc_s == 3'd0) || (kerns_s == 3'd0) || (rc_s == 8'd0);
  assign geom_oob  = span > {9'd0, cols_s};

  assign t_last = (t_cnt == kc_s - 3'd1);
  assign r_last = (r_cnt == rc_s - 8'd1);
  assign k_last = (k_cnt == kerns_s - 3'd1);

  assign img_addr  = r_base + IA_W'(t_cnt);
  assign kern_addr = k_base + {3'd0, t_cnt};
  assign acc_en    = en_dl[RD_LAT-1];
  assign acc_clr   = en_dl[RD_LAT-1] & first_dl[RD_LAT-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      S_IDLE:  if (launch) state_nxt = S_CHECK;
      S_CHECK: state_nxt = (geom_zero || geom_oob) ? S_DONE : S_RUN;
      S_RUN: begin
        if (dp_ready) begin
          rd_en = 1'b1;
          if (t_last && r_last && k_last) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (soft_reset) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_d    <= 1'b0;
      kc_s       <= '0;
      kerns_s    <= '0;
      cols_s     <= '0;
      rc_s       <= '0;
      stride_s   <= '0;
      t_cnt      <= '0;
      k_cnt      <= '0;
      r_cnt      <= '0;
      r_base     <= '0;
      k_base     <= '0;
      out_idx    <= '0;
      drain_cnt  <= '0;
      en_dl      <= '0;
      first_dl   <= '0;
      last_dl    <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_dl[i] <= '0;
      res_wr     <= 1'b0;
      res_addr   <= '0;
      done       <= 1'b0;
      err_bounds <= 1'b0;
      ovf_flag   <= 1'b0;
    end else if (soft_reset) begin
      // start_d follows start so a level still held high cannot relaunch.
      start_d    <= start;
      t_cnt      <= '0;
      k_cnt      <= '0;
      r_cnt      <= '0;
      r_base     <= '0;
      k_base     <= '0;
      out_idx    <= '0;
      drain_cnt  <= '0;
      en_dl      <= '0;
      first_dl   <= '0;
      last_dl    <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_dl[i] <= '0;
      res_wr     <= 1'b0;
      res_addr   <= '0;
      done       <= 1'b0;
      err_bounds <= 1'b0;
      ovf_flag   <= 1'b0;
    end else begin
      start_d <= start;

      if (state == S_IDLE && launch) begin
        kc_s       <= kern_cols;
        kerns_s    <= kerns;
        cols_s     <= cols;
        rc_s       <= result_cols;
        stride_s   <= (stride == 8'd0) ? 8'd1 : stride;
        done       <= 1'b0;
        err_bounds <= 1'b0;
        ovf_flag   <= 1'b0;
      end else if (busy && accum_ovrflow) begin
        ovf_flag <= 1'b1;
      end

      if (state == S_CHECK) begin
        t_cnt   <= '0;
        k_cnt   <= '0;
        r_cnt   <= '0;
        r_base  <= '0;
        k_base  <= '0;
        out_idx <= '0;
        if (!geom_zero && geom_oob) err_bounds <= 1'b1;
      end

      // Running bases replace r*stride and k*kern_cols products.
      if (rd_en) begin
        if (t_last) begin
          t_cnt   <= '0;
          out_idx <= out_idx + 11'd1;
          if (r_last) begin
            r_cnt  <= '0;
            r_base <= '0;
            k_cnt  <= k_cnt + 3'd1;
            k_base <= k_base + {3'd0, kc_s};
          end else begin
            r_cnt  <= r_cnt + 8'd1;
            r_base <= r_base + IA_W'(stride_s);
          end
        end else begin
          t_cnt <= t_cnt + 3'd1;
        end
      end

      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
      if (state == S_DONE) done <= 1'b1;

      en_dl[0]    <= rd_en;
      first_dl[0] <= (t_cnt == 3'd0);
      last_dl[0]  <= t_last;
      addr_dl[0]  <= out_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        en_dl[i]    <= en_dl[i-1];
        first_dl[i] <= first_dl[i-1];
        last_dl[i]  <= last_dl[i-1];
        addr_dl[i]  <= addr_dl[i-1];
      end

      res_wr   <= en_dl[RD_LAT-1] & last_dl[RD_LAT-1];
      res_addr <= addr_dl[RD_LAT-1];
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: directed and random jobs checked against a
// nested-loop model of the issue order and strobe timing.
module tb_conv_seq_ctrl;

  localparam int RD_LAT = 1;
  localparam int IA_W   = 16;
  localparam int EW     = 35;
  localparam int PAT_N  = 512;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            soft_reset;
  logic [2:0]      kern_cols;
  logic [7:0]      cols;
  logic [2:0]      kerns;
  logic [7:0]      stride;
  logic [7:0]      result_cols;
  logic            dp_ready;
  logic            accum_ovrflow;
  logic            rd_en;
  logic [IA_W-1:0] img_addr;
  logic [5:0]      kern_addr;
  logic            acc_clr;
  logic            acc_en;
  logic            res_wr;
  logic [10:0]     res_addr;
  logic            busy;
  logic            done;
  logic            err_bounds;
  logic            ovf_flag;
  logic [2:0]      state_dbg;

  conv_seq_ctrl #(.RD_LAT(RD_LAT), .IA_W(IA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .soft_reset(soft_reset),
    .kern_cols(kern_cols), .cols(cols), .kerns(kerns), .stride(stride),
    .result_cols(result_cols), .dp_ready(dp_ready), .accum_ovrflow(accum_ovrflow),
    .rd_en(rd_en), .img_addr(img_addr), .kern_addr(kern_addr), .acc_clr(acc_clr),
    .acc_en(acc_en), .res_wr(res_wr), .res_addr(res_addr), .busy(busy),
    .done(done), .err_bounds(err_bounds), .ovf_flag(ovf_flag), .state_dbg(state_dbg)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---- scoreboard ----
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // expected issue entries: {res[34:24], last[23], first[22], kern[21:16], img[15:0]}
  logic [EW-1:0] exp_q[$];
  logic [32:0]   acc_q[$];   // {cycle, first_tap}
  logic [42:0]   res_q[$];   // {cycle, res_addr}

  bit            job_active = 1'b0;
  bit            done_seen;
  int            done_off;
  int            launch_cyc;
  int            rd_cnt;
  int            wr_cnt;
  logic [EW-1:0] e;
  logic [32:0]   a;
  logic [42:0]   rq;
  logic [31:0]   c32;
  bit            exp_acc, exp_wr;

  always @(negedge clk) begin
    if (job_active) begin
      if (rd_en) begin
        rd_cnt++;
        if (exp_q.size() == 0) begin
          check("rd_extra", rd_en, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("img_addr", img_addr, e[15:0]);
          check("kern_addr", kern_addr, e[21:16]);
          c32 = cyc + RD_LAT;
          acc_q.push_back({c32, e[22]});
          if (e[23]) begin
            c32 = cyc + RD_LAT + 1;
            res_q.push_back({c32, e[34:24]});
          end
        end
      end
      exp_acc = (acc_q.size() > 0) && (acc_q[0][32:1] == cyc);
      if (acc_en || exp_acc) begin
        check("acc_en", acc_en, exp_acc);
        if (exp_acc) begin
          a = acc_q.pop_front();
          check("acc_clr", acc_clr, a[0]);
        end
      end
      exp_wr = (res_q.size() > 0) && (res_q[0][42:11] == cyc);
      if (res_wr || exp_wr) begin
        if (res_wr) wr_cnt++;
        check("res_wr", res_wr, exp_wr);
        if (exp_wr) begin
          rq = res_q.pop_front();
          check("res_addr", res_addr, rq[10:0]);
        end
      end
      if (done && !done_seen) begin
        done_seen = 1'b1;
        done_off  = cyc - launch_cyc;
      end
    end
  end

  // ---- driver tasks ----
  task automatic run_job(input int kc, input int cl, input int kn, input int st,
                         input int rc, input int mode, input int ovf_off);
    int  st_eff, t_exp, outs, exp_done, cnt, o;
    bit  zero, oob, exp_ovf;
    bit  pat[PAT_N];
    logic [EW-1:0] ent;
    st_eff = (st == 0) ? 1 : st;
    zero   = (kc == 0) || (kn == 0) || (rc == 0);
    oob    = !zero && ((rc - 1) * st_eff + kc > cl);
    exp_q.delete();
    acc_q.delete();
    res_q.delete();
    t_exp = 0;
    outs  = 0;
    if (!zero && !oob) begin
      for (int k = 0; k < kn; k++)
        for (int r = 0; r < rc; r++)
          for (int t = 0; t < kc; t++) begin
            ent = {11'(k * rc + r), (t == kc - 1), (t == 0), 6'(k * kc + t), 16'(r * st_eff + t)};
            exp_q.push_back(ent);
          end
      t_exp = kc * kn * rc;
      outs  = kn * rc;
    end
    for (int i = 0; i < PAT_N; i++) pat[i] = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (mode == 1) for (int i = 5; i < 10; i++) pat[i] = 1'b0;
    if (t_exp == 0) begin
      exp_done = 2;
    end else begin
      cnt = 0;
      exp_done = 0;
      for (int i = 1; i < PAT_N && exp_done == 0; i++) begin
        if (pat[i]) cnt++;
        if (cnt == t_exp) exp_done = i + RD_LAT + 3;
      end
    end
    exp_ovf = (ovf_off >= 0) && (ovf_off < exp_done);

    @(posedge clk); #1;
    kern_cols   = 3'(kc);
    cols        = 8'(cl);
    kerns       = 3'(kn);
    stride      = 8'(st);
    result_cols = 8'(rc);
    start       = 1'b1;
    @(posedge clk); #1;
    launch_cyc = cyc;
    rd_cnt     = 0;
    wr_cnt     = 0;
    done_seen  = 1'b0;
    job_active = 1'b1;
    o = 0;
    dp_ready      = pat[0];
    accum_ovrflow = (ovf_off == 0);
    while (!done_seen && o < PAT_N - 1) begin
      @(posedge clk); #1;
      o++;
      dp_ready      = pat[o];
      accum_ovrflow = (o == ovf_off);
      if (o == 1) begin
        kern_cols   = 3'($urandom);
        cols        = 8'($urandom);
        kerns       = 3'($urandom);
        stride      = 8'($urandom);
        result_cols = 8'($urandom);
      end
      if (exp_done > 8 && o == 3) start = 1'b0;
      if (exp_done > 8 && o == 5) start = 1'b1;
    end
    dp_ready      = 1'b1;
    accum_ovrflow = 1'b0;
    start         = 1'b0;
    check("done_seen", done_seen, 1'b1);
    check("done_lat", done_off, exp_done);
    repeat (3) @(negedge clk);
    #1;
    job_active = 1'b0;
    check("done_flag", done, 1'b1);
    check("err_bounds", err_bounds, oob);
    check("ovf_flag", ovf_flag, exp_ovf);
    check("busy_idle", busy, 1'b0);
    check("rd_count", rd_cnt, t_exp);
    check("wr_count", wr_cnt, outs);
    check("issue_left", exp_q.size(), 0);
    check("acc_left", acc_q.size(), 0);
  endtask

  task automatic soft_reset_test();
    int seen;
    @(posedge clk); #1;
    kern_cols = 3'd3; cols = 8'd8; kerns = 3'd1; stride = 8'd1; result_cols = 8'd6;
    dp_ready  = 1'b1;
    start     = 1'b1;
    repeat (4) @(posedge clk);
    #1 accum_ovrflow = 1'b1;
    @(posedge clk); #1;
    accum_ovrflow = 1'b0;
    soft_reset    = 1'b1;
    @(negedge clk);
    check("sr_busy_before", busy, 1'b1);
    check("sr_ovf_before", ovf_flag, 1'b1);
    @(posedge clk); #1;
    soft_reset = 1'b0;
    @(negedge clk);
    check("sr_busy", busy, 1'b0);
    check("sr_rd_en", rd_en, 1'b0);
    check("sr_acc_en", acc_en, 1'b0);
    check("sr_res_wr", res_wr, 1'b0);
    check("sr_done", done, 1'b0);
    check("sr_ovf", ovf_flag, 1'b0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || rd_en) seen++;
    end
    check("sr_no_relaunch", seen, 0);
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    // soft_reset in the same cycle as a start edge, start then held
    #1;
    start      = 1'b1;
    soft_reset = 1'b1;
    @(posedge clk); #1;
    soft_reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy) seen++;
    end
    check("sr_launch_race", seen, 0);
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // ---- main sequence ----
  initial begin
    int kc, cl, kn, st, rc, ov;
    reset = 1'b0; start = 1'b0; soft_reset = 1'b0;
    kern_cols = '0; cols = '0; kerns = '0; stride = '0; result_cols = '0;
    dp_ready = 1'b1; accum_ovrflow = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err_bounds, 1'b0);
    check("rst_ovf", ovf_flag, 1'b0);
    check("rst_acc", {acc_en, acc_clr, res_wr}, 3'b000);
    check("rst_addr", img_addr, 16'd0);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    run_job(3, 8, 1, 1, 6, 0, -1);   // baseline, 22-cycle job
    run_job(3, 8, 1, 1, 6, 1, 7);    // 5-cycle stall plus overflow pulse
    run_job(2, 9, 2, 3, 3, 0, -1);   // two kernels, stride 3; ovf must clear
    run_job(3, 8, 1, 2, 4, 0, -1);   // out of bounds
    run_job(2, 4, 1, 0, 3, 0, -1);   // stride 0 acts as 1
    run_job(2, 4, 0, 1, 3, 0, -1);   // no kernels
    run_job(7, 7, 1, 9, 1, 0, 1);    // single output exactly fits, ovf during CHECK
    soft_reset_test();
    run_job(3, 8, 1, 1, 6, 0, -1);   // relaunch after start fell

    for (int n = 0; n < 15; n++) begin
      kc = int'($urandom_range(1, 4));
      kn = int'($urandom_range(0, 3));
      rc = int'($urandom_range(1, 6));
      st = int'($urandom_range(0, 3));
      cl = int'($urandom_range(2, 20));
      if ($urandom_range(0, 1) == 1) ov = int'($urandom_range(0, 40));
      else ov = -1;
      run_job(kc, cl, kn, st, rc, 2, ov);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
Sequencer for the convolution datapath, driven by the ctrl/status register fields start, soft_reset, kern_cols, cols, kerns, stride and result_cols.
- On a start rising edge it validates the geometry, then issues one image/kernel read per cycle for every (kernel, output, tap) triple.
- It drives the accumulator clear/enable and result-write strobes, aligned to the fixed memory read latency.
- It returns done, bounds-error and overflow status to the register block.

Parameters:
RD_LAT, 1, fixed read latency (cycles, >=1) of image/kernel memories; aligns acc/result strobes.
IA_W, 16, image address width.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  register level; rising edge launches a job
soft_reset  in  1  synchronous clear, active high
kern_cols  in  3  taps per kernel
cols  in  8  image row length
kerns  in  3  number of kernels
stride  in  8  output step (0 treated as 1)
result_cols  in  8  outputs per kernel
dp_ready  in  1  datapath accepts an issue this cycle
accum_ovrflow  in  1  datapath overflow pulse
rd_en  out  1  image+kernel read strobe
img_addr  out  IA_W  r*stride+t
kern_addr  out  6  k*kern_cols+t
acc_clr  out  1  first tap of an output (RD_LAT after issue)
acc_en  out  1  tap accumulate (RD_LAT after issue)
res_wr  out  1  result write (RD_LAT+1 after last-tap issue)
res_addr  out  11  k*result_cols+r, aligned with res_wr
busy  out  1  state != IDLE
done  out  1  sticky job-complete
err_bounds  out  1  sticky geometry error
ovf_flag  out  1  sticky overflow seen during job

Behaviour:
- Reset (async, low): all outputs 0; FSM IDLE; counters, delay lines and start_d cleared.
- start edge detection: start_d registered; launch = start & ~start_d, evaluated only in IDLE. Edges in other states are ignored.
- FSM states and transitions:
  - IDLE: on launch, clear done/err_bounds/ovf_flag and go to CHECK.
  - CHECK (1 cycle):
    - If kern_cols==0, kerns==0 or result_cols==0: go to DONE, no accesses.
    - Else if (result_cols-1)*stride_eff + kern_cols > cols (9+ bit compare, no truncation): set err_bounds and go to DONE.
    - Else load k=r=t=0 and go to RUN.
  - RUN:
    - Each cycle with dp_ready=1: rd_en=1, outputs the current addresses, then advances t.
    - When t wraps past kern_cols-1: t=0, r++. When r wraps past result_cols-1: r=0, k++.
    - After issuing the last triple, go to DRAIN.
    - dp_ready=0: rd_en=0, counters hold; delay lines keep shifting.
  - DRAIN: RD_LAT+1 cycles, no issues; then DONE.
  - DONE: 1 cycle; set done; go to IDLE.
- Strobe alignment:
  - Issue-stage tags (first_tap = t==0, last_tap, res_addr) travel through an RD_LAT-deep delay line.
  - acc_en = delayed rd_en; acc_clr = acc_en & delayed first_tap.
  - res_wr is acc_en & delayed last_tap, registered one more cycle; res_addr is registered with it.
- Address arithmetic: img_addr = r*stride_eff + t, computed from registered running bases (r_base += stride_eff per output). No multiplier in the issue path.
- Geometry inputs are sampled into shadow registers at launch; register changes mid-job have no effect.
- ovf_flag: set by accum_ovrflow while busy; held until next launch or soft_reset.
- soft_reset (any state):
  - Next cycle: FSM IDLE, counters and delay lines cleared, rd_en/acc/res strobes 0.
  - done, err_bounds and ovf_flag cleared.
  - start_d is loaded with start, so a held start does not relaunch.
- Simultaneous soft_reset and launch: soft_reset wins.
- Throughput: one tap per cycle. Cycles from the launch edge to done=1 = T + RD_LAT + 3 with no stalls, where T = kerns*result_cols*kern_cols.

Test Plan:
- kern_cols=3, cols=8, kerns=1, stride=1, result_cols=6, RD_LAT=1 -> img_addr 0,1,2,1,2,3,…,5,6,7; kern_addr 0,1,2 repeating; 6 res_wr at res_addr 0..5; done rises 22 cycles after launch; err_bounds=0.
- kern_cols=2, cols=9, kerns=2, stride=3, result_cols=3 -> img_addr 0,1,3,4,6,7 per kernel; kern_addr 0,1 then 2,3; res_addr 0..2 then 3..5; 12 rd_en pulses total.
- kern_cols=3, cols=8, stride=2, result_cols=4 (6+3>8) -> err_bounds=1, done=1, zero rd_en/res_wr pulses.
- First scenario with dp_ready held low 5 cycles mid-run, plus an accum_ovrflow pulse -> address sequence unchanged, done delayed by exactly 5 cycles, ovf_flag=1 until next launch.
- soft_reset during RUN, and start held high throughout -> busy=0 and strobes 0 next cycle; done=0; no relaunch until start falls and rises again.
- stride=0 and kerns=0 -> stride=0 (kern_cols=2, cols=4, result_cols=3) gives img_addr 0,1,1,2,2,3; kerns=0 -> done after CHECK with no reads.
